cond_flag_writer: RTL and testbench
===================================

# cond_flag_writer

Producer end of the {N,Z,C,V} flags interface consumed by the control unit's condition checker. Derives NZCV from the execute-stage ALU result, holds them in a one-entry pending stage, and commits them to the architectural flags register under FlagW and CondEx gating. Sits between the ALU and the condition-check logic. Exports a hazard signal so decode can stall on an in-flight flag write.

## Interface
- WIDTH, 32, ALU datapath width; minimum 2.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Valid  in  1  execute-stage instruction is valid this cycle.
- Stall  in  1  pipeline hold; freezes all state except reset and Flush.
- Flush  in  1  kills the pending entry and this cycle's capture.
- ALUResult  in  WIDTH  ALU result.
- ALUCarry  in  1  adder carry-out.
- ALUOp  in  2  00 add, 01 sub, 10 and, 11 orr.
- SrcAMsb  in  1  MSB of operand A.
- SrcBMsb  in  1  MSB of operand B, before any inversion.
- FlagW  in  2  [1] writes {N,Z}, [0] writes {C,V}.
- CondEx  in  1  condition-check result for the executing instruction.
- Flags  out  4  architectural {N,Z,C,V}; feeds the condition checker.
- FlagsPending  out  1  pending entry valid with a non-zero write mask.
- FlagsUpdated  out  1  registered one-cycle pulse after each commit.

## Operation
- Flag derivation (combinational):
  - N = ALUResult[WIDTH-1].
  - Z = (ALUResult == 0).
  - C = ALUCarry.
  - V for add = (SrcAMsb == SrcBMsb) & (N != SrcAMsb).
  - V for sub = (SrcAMsb != SrcBMsb) & (N != SrcAMsb).
- Effective mask = FlagW & {2{CondEx}}. For logic ops (ALUOp[1]=1), mask bit [0] is forced to 0, so logic ops never update C or V.
- Pending entry: pend_v, pend_flags[3:0], pend_w[1:0].
- Per-cycle priority, evaluated at the clock edge:
  1. Flush=1: pend_v<=0. No commit and no capture this cycle, regardless of Stall.
  2. Stall=1: all registers hold.
  3. Otherwise:
     - If pend_v=1, commit: Flags[3:2]<=pend_flags[3:2] if pend_w[1]; Flags[1:0]<=pend_flags[1:0] if pend_w[0].
     - FlagsUpdated<=pend_v & |pend_w, otherwise 0.
     - Capture: pend_v<=Valid; pend_flags<=derived NZCV; pend_w<=effective mask.
- Commit and capture in the same cycle are legal: back-to-back instructions commit in order, one per cycle.
- A pending entry with pend_w=00 commits nothing and produces no FlagsUpdated pulse.
- FlagsPending = pend_v & |pend_w. Combinational from registers.
- Reset: Flags=0000, pend_v=0, pend_flags=0000, pend_w=00, FlagsUpdated=0, FlagsPending=0. An asserted reset mid-operation discards the pending entry immediately.

## Timing
- Capture at edge k. Commit at edge k+1, provided there is no Stall or Flush in that cycle.
- Registered Flags are valid after edge k+1. FlagsUpdated is high during the cycle after edge k+1.
- Each Stall cycle between capture and commit adds one cycle of latency.
- Flush in the commit cycle drops the entry. Flags stay unchanged.
- FlagsPending rises after edge k and falls after the commit edge.

## Configuration
- FLAG_BYPASS_EN defined:
  - Flags output = architectural flags merged with pend_flags per pend_w, whenever pend_v=1 and Flush=0.
  - The consumer sees new flags one cycle after capture, in the cycle before commit.
  - FlagsPending is tied to 0.
- FLAG_BYPASS_EN undefined:
  - Flags is driven directly from the architectural register.
  - FlagsPending behaves as specified above.
- Commit timing and FlagsUpdated behaviour are identical in both builds.

## Test plan
- Reset: assert rst_n=0 with pend_v=1 and Flags=1111 → all outputs read 0 asynchronously, before the next clock edge.
- Sub overflow: ALUOp=01, SrcAMsb=0, SrcBMsb=1, ALUResult=0x80000000, ALUCarry=0, FlagW=11, CondEx=1, Valid=1 → after two edges Flags=1001; FlagsUpdated pulses once.
- Logic op with CondEx gating:
  - Start from Flags=0011. ALUOp=10, ALUResult=0, FlagW=11, CondEx=1 → Flags=0111, with C and V preserved.
  - Repeat with CondEx=0 → Flags unchanged and no pulse.
- Back-to-back: add result 0 with carry (FlagW=11), then sub result 0xFFFFFFFF (FlagW=10) on consecutive cycles → Flags=0110, then 1010. FlagsUpdated high for two consecutive cycles.
- Stall/flush:
  - Capture, then hold Stall=1 for 3 cycles → Flags unchanged and FlagsPending=1 throughout; commit on the first cycle with Stall=0.
  - Capture, then Flush=1 together with Stall=1 → entry dropped, no commit.
- With FLAG_BYPASS_EN defined: capture N=1 → Flags[3]=1 in the cycle after capture; FlagsPending stays 0.

Source files
------------

// File: rtl/cond_flag_writer_if.sv
// Flags-producer bundle between the execute stage and the condition checker.
// The master side drives ALU results and gating; the slave (cond_flag_writer) returns NZCV.
interface cond_flag_writer_if #(
  parameter int WIDTH = 32
);
  logic             Valid;
  logic             Stall;
  logic             Flush;
  logic [WIDTH-1:0] ALUResult;
  logic             ALUCarry;
  logic [1:0]       ALUOp;
  logic             SrcAMsb;
  logic             SrcBMsb;
  logic [1:0]       FlagW;
  logic             CondEx;
  logic [3:0]       Flags;
  logic             FlagsPending;
  logic             FlagsUpdated;

  modport master (
    output Valid, Stall, Flush, ALUResult, ALUCarry, ALUOp,
           SrcAMsb, SrcBMsb, FlagW, CondEx,
    input  Flags, FlagsPending, FlagsUpdated
  );

  modport slave (
    input  Valid, Stall, Flush, ALUResult, ALUCarry, ALUOp,
           SrcAMsb, SrcBMsb, FlagW, CondEx,
    output Flags, FlagsPending, FlagsUpdated
  );
endinterface

// File: rtl/cond_flag_writer.sv
// Derives NZCV from the ALU result, stages it one cycle, then commits under FlagW/CondEx.
// Optional build macro FLAG_BYPASS_EN forwards the pending entry onto Flags before commit.
module cond_flag_writer #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  cond_flag_writer_if.slave fw
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_ORR = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  alu_op_e    op;
  nzcv_t      derived;
  logic [1:0] eff_w;

  nzcv_t      arch_flags;
  logic       pend_v;
  nzcv_t      pend_flags;
  logic [1:0] pend_w;
  logic       flags_updated;

  assign op = alu_op_e'(fw.ALUOp);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    derived   = '0;
    derived.n = fw.ALUResult[WIDTH-1];
    derived.z = ~|fw.ALUResult;
    derived.c = fw.ALUCarry;
    case (op)
      OP_ADD:  derived.v = (fw.SrcAMsb == fw.SrcBMsb) & (derived.n != fw.SrcAMsb);
      OP_SUB:  derived.v = (fw.SrcAMsb != fw.SrcBMsb) & (derived.n != fw.SrcAMsb);
      default: derived.v = 1'b0;
    endcase
  end

  // Logic ops leave C and V to whoever last produced an arithmetic result.
  always_comb begin
    eff_w = fw.FlagW & {2{fw.CondEx}};
    if (fw.ALUOp[1]) eff_w[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arch_flags    <= '0;
      pend_v        <= 1'b0;
      pend_flags    <= '0;
      pend_w        <= 2'b00;
      flags_updated <= 1'b0;
    end else if (fw.Flush) begin
      // Flush beats Stall: the staged entry dies without committing.
      pend_v        <= 1'b0;
      flags_updated <= 1'b0;
    end else if (!fw.Stall) begin
      if (pend_v && pend_w[1]) begin
        arch_flags.n <= pend_flags.n;
        arch_flags.z <= pend_flags.z;
      end
      if (pend_v && pend_w[0]) begin
        arch_flags.c <= pend_flags.c;
        arch_flags.v <= pend_flags.v;
      end
      flags_updated <= pend_v & (|pend_w);
      pend_v        <= fw.Valid;
      pend_flags    <= derived;
      pend_w        <= eff_w;
    end
  end

  assign fw.FlagsUpdated = flags_updated;

`ifdef FLAG_BYPASS_EN
  // Consumer sees the staged flags one cycle early, so decode never needs to stall on them.
  always_comb begin
    fw.Flags = arch_flags;
    if (pend_v && !fw.Flush) begin
      if (pend_w[1]) fw.Flags[3:2] = {pend_flags.n, pend_flags.z};
      if (pend_w[0]) fw.Flags[1:0] = {pend_flags.c, pend_flags.v};
    end
  end
  assign fw.FlagsPending = 1'b0;
`else
  assign fw.Flags        = arch_flags;
  assign fw.FlagsPending = pend_v & (|pend_w);
`endif

endmodule

// File: tb/tb_cond_flag_writer.sv
// Directed test-plan steps followed by a random run, all checked against an
// operand-level reference model (signed arithmetic, queue for the pending stage).
module tb_cond_flag_writer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic [3:0] f;
    logic [1:0] w;
  } entry_t;

  entry_t     pend_q[$];
  logic [3:0] m_arch;
  logic       m_upd;

  cond_flag_writer_if #(.WIDTH(32)) fw();

  cond_flag_writer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fw    (fw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    fw.Valid     = 1'b0;
    fw.Stall     = 1'b0;
    fw.Flush     = 1'b0;
    fw.ALUResult = '0;
    fw.ALUCarry  = 1'b0;
    fw.ALUOp     = 2'b00;
    fw.SrcAMsb   = 1'b0;
    fw.SrcBMsb   = 1'b0;
    fw.FlagW     = 2'b00;
    fw.CondEx    = 1'b0;
  endtask

  task automatic model_reset();
    pend_q.delete();
    m_arch = 4'b0000;
    m_upd  = 1'b0;
  endtask

  // One clock cycle: drive, check against the model, advance the model, take the edge.
  task automatic cyc(input bit valid, input bit stall, input bit flush,
                     input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] flagw, input bit condex);
    logic [31:0] r;
    logic        carry;
    logic        v;
    logic [1:0]  mask;
    logic [3:0]  exp_flags;
    longint      exact;
    entry_t      e;
    v = 1'b0;
    case (op)
      2'b00: begin {carry, r} = {1'b0, a} + {1'b0, b};
               exact = longint'($signed(a)) + longint'($signed(b));
               v = (exact != longint'($signed(r))); end
      2'b01: begin r = a - b; carry = (a >= b);
               exact = longint'($signed(a)) - longint'($signed(b));
               v = (exact != longint'($signed(r))); end
      2'b10: begin r = a & b; carry = 1'($urandom); end
      default: begin r = a | b; carry = 1'($urandom); end
    endcase
    mask = flagw & {2{condex}};
    if (op[1]) mask[0] = 1'b0;

    fw.Valid = valid; fw.Stall = stall; fw.Flush = flush;
    fw.ALUResult = r; fw.ALUCarry = carry; fw.ALUOp = op;
    fw.SrcAMsb = a[31]; fw.SrcBMsb = b[31]; fw.FlagW = flagw; fw.CondEx = condex;
    #1;
    exp_flags = m_arch;
`ifdef FLAG_BYPASS_EN
    if (pend_q.size() != 0 && !flush) begin
      if (pend_q[0].w[1]) exp_flags[3:2] = pend_q[0].f[3:2];
      if (pend_q[0].w[0]) exp_flags[1:0] = pend_q[0].f[1:0];
    end
    check("model_pending", {3'b0, fw.FlagsPending}, 4'b0);
`else
    check("model_pending", {3'b0, fw.FlagsPending},
          {3'b0, (pend_q.size() != 0) && (pend_q[0].w != 2'b00)});
`endif
    check("model_flags", fw.Flags, exp_flags);
    check("model_updated", {3'b0, fw.FlagsUpdated}, {3'b0, m_upd});

    if (flush) begin
      pend_q.delete();
      m_upd = 1'b0;
    end else if (!stall) begin
      m_upd = 1'b0;
      if (pend_q.size() != 0) begin
        e = pend_q.pop_front();
        if (e.w[1]) m_arch[3:2] = e.f[3:2];
        if (e.w[0]) m_arch[1:0] = e.f[1:0];
        m_upd = (e.w != 2'b00);
      end
      if (valid) pend_q.push_back('{f: {r[31], r == 32'd0, carry, v}, w: mask});
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    checks = 0;
    errors = 0;
    model_reset();
    drive_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_flags", fw.Flags, 4'b0000);
    check("reset_pending", {3'b0, fw.FlagsPending}, 4'b0);
    check("reset_updated", {3'b0, fw.FlagsUpdated}, 4'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sub overflow: 0 - 0x80000000 -> 0x80000000, NZCV = 1001.
    cyc(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0000, 32'h8000_0000, 2'b11, 1'b1);
`ifdef FLAG_BYPASS_EN
    check("bypass_early_n", {3'b0, fw.Flags[3]}, 4'b0001);
    check("bypass_pending", {3'b0, fw.FlagsPending}, 4'b0);
`else
    check("sub_pending", {3'b0, fw.FlagsPending}, 4'b0001);
`endif
    idle_cyc();
    check("sub_flags", fw.Flags, 4'b1001);
    check("sub_pulse", {3'b0, fw.FlagsUpdated}, 4'b0001);
    idle_cyc();
    check("sub_pulse_end", {3'b0, fw.FlagsUpdated}, 4'b0);

    // Reach 0011, then AND with zero result -> 0111, then a CondEx=0 ORR leaves it.
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 1'b1);
    idle_cyc();
    check("setup_0011", fw.Flags, 4'b0011);
    cyc(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0000, 32'h1234_5678, 2'b11, 1'b1);
    idle_cyc();
    check("logic_flags", fw.Flags, 4'b0111);
    cyc(1'b1, 1'b0, 1'b0, 2'b11, 32'h8000_0000, 32'h0000_0000, 2'b11, 1'b0);
    idle_cyc();
    check("condex0_flags", fw.Flags, 4'b0111);
    check("condex0_pulse", {3'b0, fw.FlagsUpdated}, 4'b0);

    // Back-to-back: add 1+(-1) = 0 with carry, then sub 0-1 writing only N,Z.
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 2'b11, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0000, 32'h0000_0001, 2'b10, 1'b1);
    check("b2b_first", fw.Flags, 4'b0110);
    check("b2b_pulse1", {3'b0, fw.FlagsUpdated}, 4'b0001);
    idle_cyc();
    check("b2b_second", fw.Flags, 4'b1010);
    check("b2b_pulse2", {3'b0, fw.FlagsUpdated}, 4'b0001);
    idle_cyc();

    // Capture 0x7FFFFFFF + 1 (NZCV 1001), stall three cycles, then commit.
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 2'b11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
`ifndef FLAG_BYPASS_EN
      check("stall_flags", fw.Flags, 4'b1010);
      check("stall_pending", {3'b0, fw.FlagsPending}, 4'b0001);
`endif
    end
    idle_cyc();
    check("stall_commit", fw.Flags, 4'b1001);
    check("stall_pulse", {3'b0, fw.FlagsUpdated}, 4'b0001);

    // Capture 5-5 (0110), then Flush with Stall: entry dropped.
    cyc(1'b1, 1'b0, 1'b0, 2'b01, 32'd5, 32'd5, 2'b11, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
    idle_cyc();
    check("flush_flags", fw.Flags, 4'b1001);
    check("flush_pulse", {3'b0, fw.FlagsUpdated}, 4'b0);
    check("flush_pending", {3'b0, fw.FlagsPending}, 4'b0);

    // Asynchronous reset with an entry in flight.
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'd1, 32'hFFFF_FFFF, 2'b11, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_flags", fw.Flags, 4'b0000);
    check("midreset_pending", {3'b0, fw.FlagsPending}, 4'b0);
    check("midreset_updated", {3'b0, fw.FlagsUpdated}, 4'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0)
        rb = (rop == 2'b01) ? ra : ((rop == 2'b00) ? -ra : 32'd0);
      if (rop == 2'b11 && $urandom_range(0, 5) == 0) begin ra = 0; rb = 0; end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
          rop, ra, rb, 2'($urandom), $urandom_range(0, 4) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
